// File: rtl/usb_rx_decoder_if.sv
// Bus-side lines and RX byte-stream outputs of the USB receive decoder.
interface usb_rx_decoder_if;
  logic       dplus_in;
  logic       dminus_in;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rcv_active;
  logic       rx_done;
  logic       rx_error;

  // Master drives the bus lines and consumes the decoded stream.
  modport master (
    output dplus_in,
    output dminus_in,
    input  rx_data,
    input  rx_data_valid,
    input  rcv_active,
    input  rx_done,
    input  rx_error
  );

  // Slave is the decoder itself.
  modport slave (
    input  dplus_in,
    input  dminus_in,
    output rx_data,
    output rx_data_valid,
    output rcv_active,
    output rx_done,
    output rx_error
  );
endinterface

// File: rtl/usb_rx_decoder.sv
// USB receive decoder: synchronizes D+/D-, recovers bit timing from D+ edges,
// NRZI-decodes, removes stuffed bits, checks SYNC/EOP and emits bytes.
module usb_rx_decoder #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input logic             clk,
  input logic             n_rst,
  usb_rx_decoder_if.slave bus
);

  localparam int unsigned TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TimerW-1:0] SampleAt = TimerW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StReceive,
    StEop,
    StError
  } state_e;

  state_e r_state;
  state_e w_state_d;

  // Synchronizer and edge-detect flops
  logic r_dp_s1, r_dp_s2, r_dm_s1, r_dm_s2, r_dp_d;

  logic [TimerW-1:0] r_timer;
  logic              r_prev_dp;
  logic [7:0]        r_shift;
  logic [2:0]        r_bit_cnt;
  logic [2:0]        r_ones;
  logic [1:0]        r_se0_cnt;
  logic [7:0]        r_rx_data;
  logic              r_rx_data_valid;
  logic              r_rx_done;
  logic              r_rx_error;

  logic       w_d_edge;
  logic       w_sample;
  logic       w_se0;
  logic       w_j;
  logic       w_bit;
  logic       w_stuff;
  logic       w_last_bit;
  logic [7:0] w_byte;

  logic w_rcv_active;
  logic w_in_pkt;
  logic w_start;
  logic w_shift_en;
  logic w_unstuff;
  logic w_load;
  logic w_done_set;
  logic w_err_set;

  // Two-flop synchronizers; reset to idle J so release never fakes an edge
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_dp_s1 <= 1'b1;
      r_dp_s2 <= 1'b1;
      r_dm_s1 <= 1'b0;
      r_dm_s2 <= 1'b0;
      r_dp_d  <= 1'b1;
    end else begin
      r_dp_s1 <= bus.dplus_in;
      r_dp_s2 <= r_dp_s1;
      r_dm_s1 <= bus.dminus_in;
      r_dm_s2 <= r_dm_s1;
      r_dp_d  <= r_dp_s2;
    end
  end

  assign w_d_edge   = r_dp_s2 ^ r_dp_d;
  // A resync edge suppresses the sample that would fall on the same clk
  assign w_sample   = (r_timer == SampleAt) && !w_d_edge;
  assign w_se0      = !r_dp_s2 && !r_dm_s2;
  assign w_j        = r_dp_s2 && !r_dm_s2;
  assign w_bit      = (r_dp_s2 == r_prev_dp);
  assign w_stuff    = (r_ones == 3'd6);
  assign w_last_bit = (r_bit_cnt == 3'd7);
  assign w_byte     = {w_bit, r_shift[7:1]};

  // Bit timer: free-running per bit period, realigned on every D+ edge
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_timer <= '0;
    end else if (w_d_edge || (r_timer == TimerMax)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next-state logic; everything but IDLE advances only on sample strobes
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_d_edge) w_state_d = StSync;
      end
      StSync: begin
        if (w_sample) begin
          if (w_se0) begin
            w_state_d = StError;
          end else if (w_stuff) begin
            if (w_bit) w_state_d = StError;
          end else if (w_last_bit) begin
            w_state_d = (w_byte == 8'h80) ? StReceive : StError;
          end
        end
      end
      StReceive: begin
        if (w_sample) begin
          if (w_se0) begin
            w_state_d = (r_bit_cnt == 3'd0) ? StEop : StError;
          end else if (w_stuff && w_bit) begin
            w_state_d = StError;
          end
        end
      end
      StEop: begin
        if (w_sample) begin
          if (w_se0) begin
            // r_se0_cnt counts earlier consecutive SE0 samples; a third is illegal
            if (r_se0_cnt >= 2'd2) w_state_d = StError;
          end else if (w_j) begin
            w_state_d = StIdle;
          end else begin
            w_state_d = StError;
          end
        end
      end
      StError: begin
        if (w_sample && w_j && (r_se0_cnt != 2'd0)) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // FSM outputs and datapath controls
  always_comb begin
    w_rcv_active = (r_state != StIdle);
    w_in_pkt     = (r_state == StSync) || (r_state == StReceive);
    w_start      = (r_state == StIdle) && w_d_edge;
    w_shift_en   = w_sample && !w_se0 && w_in_pkt && !w_stuff;
    w_unstuff    = w_sample && !w_se0 && w_in_pkt && w_stuff;
    w_load       = w_shift_en && (r_state == StReceive) && w_last_bit;
    w_done_set   = (r_state == StEop) && (w_state_d == StIdle);
    w_err_set    = (w_state_d == StError) && (r_state != StError);
  end

  // NRZI reference level and SE0 run length, updated on every sample
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_prev_dp <= 1'b1;
      r_se0_cnt <= 2'd0;
    end else if (w_sample) begin
      if (w_se0) begin
        if (r_se0_cnt != 2'd3) r_se0_cnt <= r_se0_cnt + 2'd1;
      end else begin
        r_prev_dp <= r_dp_s2;
        r_se0_cnt <= 2'd0;
      end
    end
  end

  // Shift register, bit/ones counters and byte hand-off
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_ones    <= 3'd0;
      r_rx_data <= 8'h00;
    end else if (w_start) begin
      r_bit_cnt <= 3'd0;
      r_ones    <= 3'd0;
    end else begin
      if (w_shift_en) begin
        r_shift   <= w_byte;
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_ones    <= w_bit ? (r_ones + 3'd1) : 3'd0;
      end else if (w_unstuff) begin
        r_ones <= 3'd0;
      end
      if (w_load) r_rx_data <= w_byte;
    end
  end

  // Status strobes and sticky error flag
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rx_data_valid <= 1'b0;
      r_rx_done       <= 1'b0;
      r_rx_error      <= 1'b0;
    end else begin
      r_rx_data_valid <= w_load;
      r_rx_done       <= w_done_set;
      if (w_start) begin
        r_rx_error <= 1'b0;
      end else if (w_err_set) begin
        r_rx_error <= 1'b1;
      end
    end
  end

  assign bus.rx_data       = r_rx_data;
  assign bus.rx_data_valid = r_rx_data_valid;
  assign bus.rcv_active    = w_rcv_active;
  assign bus.rx_done       = r_rx_done;
  assign bus.rx_error      = r_rx_error;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Self-checking bench: encodes packets (stuffing + NRZI) from byte lists and
// compares the decoded byte stream and status against the intended packet.
module tb_usb_rx_decoder;

  localparam int unsigned Cpb = 8;
  localparam logic [1:0] SymJ   = 2'b10;
  localparam logic [1:0] SymK   = 2'b01;
  localparam logic [1:0] SymSe0 = 2'b00;

  logic clk = 1'b0;
  logic n_rst;

  always #5 clk = ~clk;

  usb_rx_decoder_if bus ();

  usb_rx_decoder #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor: cumulative counts of strobes and captured bytes
  int         n_valid  = 0;
  int         n_done   = 0;
  int         n_active = 0;
  logic [7:0] obs_bytes[256];

  always @(negedge clk) begin
    if (bus.rx_data_valid) begin
      obs_bytes[n_valid % 256] <= bus.rx_data;
      n_valid <= n_valid + 1;
    end
    if (bus.rx_done) n_done <= n_done + 1;
    if (bus.rcv_active) n_active <= n_active + 1;
  end

  logic [7:0] pay_q[$];
  logic       bit_q[$];
  logic [1:0] sym_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Build line symbols: sync byte, payload, partial byte (all stuffed),
  // then raw unstuffed ones, then SE0,SE0,J.
  task automatic encode(input logic [7:0] sync_b, input int part_bits,
                        input logic [7:0] part_val, input int raw_ones);
    logic d_q[$];
    int   ones;
    logic lvl;
    d_q.delete();
    bit_q.delete();
    sym_q.delete();
    for (int j = 0; j < 8; j++) d_q.push_back(sync_b[j]);
    foreach (pay_q[i]) for (int j = 0; j < 8; j++) d_q.push_back(pay_q[i][j]);
    for (int j = 0; j < part_bits; j++) d_q.push_back(part_val[j]);
    ones = 0;
    foreach (d_q[i]) begin
      bit_q.push_back(d_q[i]);
      ones = d_q[i] ? ones + 1 : 0;
      if (ones == 6) begin
        bit_q.push_back(1'b0);
        ones = 0;
      end
    end
    for (int j = 0; j < raw_ones; j++) bit_q.push_back(1'b1);
    lvl = 1'b1;
    foreach (bit_q[i]) begin
      if (!bit_q[i]) lvl = ~lvl;
      sym_q.push_back(lvl ? SymJ : SymK);
    end
    sym_q.push_back(SymSe0);
    sym_q.push_back(SymSe0);
    sym_q.push_back(SymJ);
  endtask

  task automatic drive(input logic [1:0] s, input int n);
    bus.dplus_in  = s[1];
    bus.dminus_in = s[0];
    repeat (n) @(negedge clk);
  endtask

  function automatic int period(input bit alt, input int i);
    if (!alt) return Cpb;
    return (i % 2 == 1) ? 9 : 7;
  endfunction

  task automatic run_packet(input string tag, input bit alt, input int exp_n,
                            input int exp_done, input logic exp_err);
    int bv, bd, got;
    bv = n_valid;
    bd = n_done;
    foreach (sym_q[i]) drive(sym_q[i], period(alt, i));
    drive(SymJ, 24);
    got = n_valid - bv;
    check_eq({tag, "_nbytes"}, got, exp_n);
    for (int i = 0; i < exp_n && i < got; i++)
      check_eq({tag, "_byte"}, obs_bytes[(bv + i) % 256], pay_q[i]);
    check_eq({tag, "_done"}, n_done - bd, exp_done);
    check_eq({tag, "_error"}, bus.rx_error, exp_err);
    check_eq({tag, "_active"}, bus.rcv_active, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_data"}, bus.rx_data, 8'h00);
    check_eq({tag, "_valid"}, bus.rx_data_valid, 1'b0);
    check_eq({tag, "_active"}, bus.rcv_active, 1'b0);
    check_eq({tag, "_done"}, bus.rx_done, 1'b0);
    check_eq({tag, "_error"}, bus.rx_error, 1'b0);
  endtask

  initial begin
    int bv, bd, ba, n;
    bus.dplus_in  = 1'b1;
    bus.dminus_in = 1'b0;
    n_rst = 1'b0;
    #1;
    check_outputs_zero("rst");
    repeat (3) @(negedge clk);
    n_rst = 1'b1;

    // Idle J for 200 clks
    bv = n_valid; bd = n_done; ba = n_active;
    drive(SymJ, 200);
    check_eq("idle_valid", n_valid - bv, 0);
    check_eq("idle_done", n_done - bd, 0);
    check_eq("idle_active", n_active - ba, 0);
    check_outputs_zero("idle");

    // Single byte 0xA5
    pay_q = '{8'hA5};
    encode(8'h80, 0, 8'h00, 0);
    run_packet("a5", 1'b0, 1, 1, 1'b0);
    check_eq("a5_rxdata", bus.rx_data, 8'hA5);

    // 0xFF needs a stuffed zero
    pay_q = '{8'hFF};
    encode(8'h80, 0, 8'h00, 0);
    run_packet("ff", 1'b0, 1, 1, 1'b0);
    check_eq("ff_rxdata", bus.rx_data, 8'hFF);

    // Seven unstuffed ones after SYNC -> stuff error
    pay_q.delete();
    encode(8'h80, 0, 8'h00, 7);
    run_packet("stufferr", 1'b0, 0, 0, 1'b1);

    // A following good packet clears the sticky error
    pay_q = '{8'h12, 8'h34};
    encode(8'h80, 0, 8'h00, 0);
    run_packet("recover", 1'b0, 2, 1, 1'b0);

    // Bad SYNC byte
    pay_q = '{8'h55};
    encode(8'h81, 0, 8'h00, 0);
    run_packet("badsync", 1'b0, 0, 0, 1'b1);

    // SE0 after three data bits
    pay_q.delete();
    encode(8'h80, 3, 8'h05, 0);
    run_packet("partial", 1'b0, 0, 0, 1'b1);

    // Good packet to leave rx_data non-zero before the reset test
    pay_q = '{8'hC3};
    encode(8'h80, 0, 8'h00, 0);
    run_packet("pre", 1'b0, 1, 1, 1'b0);

    // Reset mid-byte, then 0x3C with 7/9 alternating periods
    pay_q = '{8'h3C};
    encode(8'h80, 0, 8'h00, 0);
    for (int i = 0; i < 14; i++) drive(sym_q[i], period(1'b1, i));
    check_eq("midpkt_active", bus.rcv_active, 1'b1);
    #2;
    n_rst = 1'b0;
    #1;
    check_outputs_zero("midrst");
    bus.dplus_in  = 1'b1;
    bus.dminus_in = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    drive(SymJ, 16);
    run_packet("jitter", 1'b1, 1, 1, 1'b0);
    check_eq("jitter_rxdata", bus.rx_data, 8'h3C);

    // Randomized multi-byte packets, nominal and jittered timing
    for (int r = 0; r < 6; r++) begin
      pay_q.delete();
      n = $urandom_range(4, 1);
      for (int k = 0; k < n; k++) pay_q.push_back(8'($urandom));
      encode(8'h80, 0, 8'h00, 0);
      run_packet("rand", (r % 2) == 1, n, 1, 1'b0);
      check_eq("rand_rxdata", bus.rx_data, pay_q[pay_q.size() - 1]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
